ffn_token_sequencer: RTL and testbench
======================================

FFN_TOKEN_SEQUENCER -- requirements
Module: ffn_token_sequencer

Interface
REQ-001 SHALL have parameter EMBED_DIM, default 4, elements per token.
REQ-002 SHALL have parameter DATA_WIDTH, default 16, bits per element (signed Q8.8).
REQ-003 SHALL have parameter QUEUE_DEPTH, default 4, input token queue entries (power of 2, >=2).
REQ-004 SHALL have parameter TIMEOUT, default 50, maximum WAIT cycles per token (>=2).
REQ-005 SHALL have port clk  input  1  single clock; all state changes on the rising edge.
REQ-006 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-007 SHALL have port in_valid  input  1  upstream token valid.
REQ-008 SHALL have port in_ready  output  1  queue not full.
REQ-009 SHALL have port in_data  input  EMBED_DIM*DATA_WIDTH  upstream token; element i at bits [i*DATA_WIDTH +: DATA_WIDTH].
REQ-010 SHALL have port ffn_valid_in  output  1  one-cycle issue pulse to the FFN.
REQ-011 SHALL have port ffn_x  output  EMBED_DIM*DATA_WIDTH  token presented to the FFN.
REQ-012 SHALL have port ffn_valid_out  input  1  FFN result valid.
REQ-013 SHALL have port ffn_y  input  EMBED_DIM*DATA_WIDTH  FFN result.
REQ-014 SHALL have port out_valid  output  1  result held for downstream.
REQ-015 SHALL have port out_ready  input  1  downstream accepts the result.
REQ-016 SHALL have port out_data  output  EMBED_DIM*DATA_WIDTH  captured result.
REQ-017 SHALL have port out_timeout  output  1  current result is a timeout; qualified by out_valid.
REQ-018 SHALL have port busy  output  1  FSM not in IDLE or queue non-empty.
REQ-019 SHALL have port done_count  output  16  tokens completed (result or timeout); wraps modulo 2^16.
REQ-020 SHALL have port timeout_count  output  16  timeouts so far; wraps modulo 2^16.

Function
REQ-021 Queue SHALL be a circular FIFO with pointer wrap-around.
REQ-022 Queue: push when in_valid && in_ready; in_ready = (count != QUEUE_DEPTH).
REQ-023 Queue: in_valid while full SHALL be ignored and SHALL NOT corrupt data.
REQ-024 Queue: a push and a pop in the same cycle SHALL leave the count unchanged; both are legal when full.
REQ-025 FSM SHALL have states IDLE, ISSUE, WAIT, HOLD.
REQ-026 IDLE -> ISSUE when the queue is non-empty.
REQ-027 ISSUE: ffn_valid_in=1 for exactly this one cycle; the next state is always WAIT; the wait counter clears to 0.
REQ-028 ffn_x SHALL equal the queue head from ISSUE through HOLD; the head SHALL NOT be popped before the HOLD handshake.
REQ-029 WAIT: ffn_valid_out=1 -> capture ffn_y into out_data, clear out_timeout, go to HOLD.
REQ-030 WAIT: when the counter reaches TIMEOUT-1 with ffn_valid_out=0 -> out_data=0, out_timeout=1, go to HOLD.
REQ-031 WAIT: if ffn_valid_out=1 in the same cycle the counter reaches TIMEOUT-1, the result SHALL win (no timeout).
REQ-032 WAIT: otherwise the counter SHALL increment.
REQ-033 HOLD: out_valid=1, with out_data and out_timeout stable until out_ready.
REQ-034 HOLD with out_ready: pop the head, increment done_count, increment timeout_count if out_timeout, go to IDLE.
REQ-035 ffn_valid_out SHALL be ignored outside WAIT, including in ISSUE.
REQ-036 Minimum latency, token pushed into an empty queue with the FSM in IDLE at edge N:
- ffn_valid_in high in the cycle after edge N+1;
- out_valid high the cycle after ffn_valid_out is sampled.

Reset
REQ-037 With rst_n=0, asynchronously:
- FSM to IDLE, queue pointers and count to 0, wait counter to 0;
- ffn_valid_in=0, out_valid=0, out_timeout=0, out_data=0, ffn_x=0;
- busy=0, done_count=0, timeout_count=0, in_ready=1.
REQ-038 Reset mid-operation SHALL discard all queued and in-flight tokens; any later ffn_valid_out is ignored because the FSM is in IDLE.

Verification
REQ-039 Push {1536,1280,768,1024}; FFN model returns the same value 3 cycles after ffn_valid_in; out_ready=1 -> exactly one ffn_valid_in pulse, ffn_x={1536,1280,768,1024}, out_data equal to it, out_timeout=0, done_count=1.
REQ-040 Push 4 distinct tokens back-to-back with out_ready=0 -> in_ready=0 after the 4th push; a 5th push is ignored; raising out_ready drains all 4 in push order with one ffn_valid_in each; done_count=4.
REQ-041 Push 1 token; FFN never responds -> out_valid exactly TIMEOUT cycles after WAIT entry; out_data=0, out_timeout=1, timeout_count=1.
REQ-042 FFN responds on the last permitted WAIT cycle -> out_timeout=0 and the result is captured.
REQ-043 Queue full and in HOLD; push and out_ready in the same cycle -> count stays 4 and the next token issues correctly.
REQ-044 Assert rst_n=0 during WAIT with 2 tokens queued, then release and send a stray ffn_valid_out -> all outputs at reset values, no out_valid, busy=0.

Source files
------------

// File: rtl/ffn_token_sequencer.sv
// FFN token sequencer: queues tokens, issues them one at a time to an FFN,
// captures the result or a timeout and holds it for the downstream consumer.
module ffn_token_sequencer #(
  parameter int EMBED_DIM   = 4,
  parameter int DATA_WIDTH  = 16,
  parameter int QUEUE_DEPTH = 4,
  parameter int TIMEOUT     = 50
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            in_valid,
  output logic                            in_ready,
  input  logic [EMBED_DIM*DATA_WIDTH-1:0] in_data,
  output logic                            ffn_valid_in,
  output logic [EMBED_DIM*DATA_WIDTH-1:0] ffn_x,
  input  logic                            ffn_valid_out,
  input  logic [EMBED_DIM*DATA_WIDTH-1:0] ffn_y,
  output logic                            out_valid,
  input  logic                            out_ready,
  output logic [EMBED_DIM*DATA_WIDTH-1:0] out_data,
  output logic                            out_timeout,
  output logic                            busy,
  output logic [15:0]                     done_count,
  output logic [15:0]                     timeout_count
);

  localparam int W  = EMBED_DIM * DATA_WIDTH;
  localparam int PW = $clog2(QUEUE_DEPTH);
  localparam int CW = $clog2(QUEUE_DEPTH + 1);
  localparam int TW = $clog2(TIMEOUT);

  localparam logic [CW-1:0] FULL = CW'(QUEUE_DEPTH);
  localparam logic [TW-1:0] LAST = TW'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    HOLD
  } state_t;

  logic [W-1:0]  mem [QUEUE_DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [CW-1:0] count;
  logic [TW-1:0] wcnt;
  state_t        state;
  logic          push;
  logic          pop;

  // The head leaves only on the downstream handshake, so a full queue
  // can still take a token in the same cycle it releases one.
  assign pop      = (state == HOLD) && out_ready;
  assign in_ready = (count != FULL);
  assign push     = in_valid && (in_ready || pop);
  assign busy     = (state != IDLE) || (count != '0);

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= in_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      wcnt          <= '0;
      ffn_valid_in  <= 1'b0;
      ffn_x         <= '0;
      out_valid     <= 1'b0;
      out_data      <= '0;
      out_timeout   <= 1'b0;
      done_count    <= '0;
      timeout_count <= '0;
    end else begin
      ffn_valid_in <= 1'b0;
      unique case (state)
        IDLE: begin
          if (count != '0) begin
            state        <= ISSUE;
            ffn_valid_in <= 1'b1;
            ffn_x        <= mem[rd_ptr];
            wcnt         <= '0;
          end
        end
        ISSUE: begin
          state <= WAIT;
          wcnt  <= '0;
        end
        WAIT: begin
          // A result on the last permitted cycle beats the timeout.
          if (ffn_valid_out) begin
            state       <= HOLD;
            out_valid   <= 1'b1;
            out_data    <= ffn_y;
            out_timeout <= 1'b0;
          end else if (wcnt == LAST) begin
            state       <= HOLD;
            out_valid   <= 1'b1;
            out_data    <= '0;
            out_timeout <= 1'b1;
          end else begin
            wcnt <= wcnt + 1'b1;
          end
        end
        HOLD: begin
          if (out_ready) begin
            state      <= IDLE;
            out_valid  <= 1'b0;
            done_count <= done_count + 16'd1;
            if (out_timeout)
              timeout_count <= timeout_count + 16'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ffn_token_sequencer.sv
// Bench for ffn_token_sequencer: randomized and directed traffic checked
// against a transaction-level scoreboard of issue times and results.
module tb_ffn_token_sequencer;

  localparam int ED = 4;
  localparam int DW = 16;
  localparam int QD = 4;
  localparam int TO = 12;
  localparam int W  = ED * DW;

  logic         clk = 1'b0;
  logic         rst_n = 1'b1;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] in_data = '0;
  logic         ffn_valid_in;
  logic [W-1:0] ffn_x;
  logic         ffn_valid_out = 1'b0;
  logic [W-1:0] ffn_y = '0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [W-1:0] out_data;
  logic         out_timeout;
  logic         busy;
  logic [15:0]  done_count;
  logic [15:0]  timeout_count;

  ffn_token_sequencer #(
    .EMBED_DIM  (ED),
    .DATA_WIDTH (DW),
    .QUEUE_DEPTH(QD),
    .TIMEOUT    (TO)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_data      (in_data),
    .ffn_valid_in (ffn_valid_in),
    .ffn_x        (ffn_x),
    .ffn_valid_out(ffn_valid_out),
    .ffn_y        (ffn_y),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_data     (out_data),
    .out_timeout  (out_timeout),
    .busy         (busy),
    .done_count   (done_count),
    .timeout_count(timeout_count)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string tag, input logic [W-1:0] got,
                     input logic [W-1:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  typedef struct {
    logic [W-1:0] data;
    int           acc;
  } tok_t;

  tok_t         q[$];
  int           c = 0;
  int           last_pop = -10;
  bit           issued = 0;
  int           issue_c = 0;
  int           d = 0;
  int           due = 0;
  logic [W-1:0] key = '0;
  logic [W-1:0] exp_data = '0;
  bit           exp_tmo = 0;
  int           m_done = 0;
  int           m_tmo = 0;
  int           force_d = -1;
  bit           ident = 0;
  int           stray = 0;

  function automatic int imax(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  function automatic logic [W-1:0] rnd_tok();
    return {$urandom, $urandom};
  endfunction

  task automatic reset_check();
    chk("rst_ffn_valid_in", W'(ffn_valid_in), '0);
    chk("rst_out_valid", W'(out_valid), '0);
    chk("rst_out_timeout", W'(out_timeout), '0);
    chk("rst_out_data", out_data, '0);
    chk("rst_ffn_x", ffn_x, '0);
    chk("rst_busy", W'(busy), '0);
    chk("rst_done_count", W'(done_count), '0);
    chk("rst_timeout_count", W'(timeout_count), '0);
    chk("rst_in_ready", W'(in_ready), W'(1'b1));
  endtask

  // One clock: check what the DUT shows now, then drive the next edge.
  task automatic step(input bit iv, input logic [W-1:0] id, input bit ordy);
    bit   exp_issue;
    bit   exp_ov;
    bit   hs;
    bit   resp;
    bit   spur;
    int   sz;
    tok_t t;
    @(negedge clk);
    exp_issue = !issued && (q.size() > 0) &&
                (c == imax(q[0].acc, last_pop) + 2);
    chk("ffn_valid_in", W'(ffn_valid_in), W'(exp_issue));
    if (exp_issue) begin
      issued  = 1;
      issue_c = c;
      if (force_d >= 0) d = force_d;
      else begin
        case ($urandom_range(0, 7))
          0:       d = TO;
          1:       d = TO + 1;
          2:       d = 0;
          3:       d = 1000;
          default: d = $urandom_range(1, 4);
        endcase
      end
      key      = ident ? '0 : rnd_tok();
      exp_tmo  = !(d >= 1 && d <= TO);
      due      = issue_c + (exp_tmo ? TO : d) + 1;
      exp_data = exp_tmo ? '0 : (q[0].data ^ key);
    end
    if (issued) chk("ffn_x", ffn_x, q[0].data);
    exp_ov = issued && (c >= due);
    chk("out_valid", W'(out_valid), W'(exp_ov));
    if (exp_ov) begin
      chk("out_data", out_data, exp_data);
      chk("out_timeout", W'(out_timeout), W'(exp_tmo));
    end
    chk("in_ready", W'(in_ready), W'(q.size() != QD));
    chk("busy", W'(busy), W'(q.size() != 0));
    chk("done_count", W'(done_count), W'(16'(m_done)));
    chk("timeout_count", W'(timeout_count), W'(16'(m_tmo)));

    resp = issued && (c - issue_c == d);
    spur = (!issued || c >= due) &&
           ((stray == 2) || (stray == 1 && $urandom_range(0, 1) == 1));
    in_valid      = iv;
    in_data       = id;
    out_ready     = ordy;
    ffn_valid_out = resp || spur;
    ffn_y         = resp ? (q[0].data ^ key) : rnd_tok();

    hs = exp_ov && ordy;
    sz = q.size();
    if (hs) begin
      q.delete(0);
      m_done++;
      if (exp_tmo) m_tmo++;
      last_pop = c;
      issued   = 0;
    end
    if (iv && (sz < QD || hs)) begin
      t.data = id;
      t.acc  = c;
      q.push_back(t);
    end
    c++;
  endtask

  task automatic apply_reset();
    #2;
    rst_n         = 1'b0;
    in_valid      = 1'b0;
    out_ready     = 1'b0;
    ffn_valid_out = 1'b0;
    #1;
    reset_check();
    q.delete();
    issued   = 0;
    last_pop = -10;
    m_done   = 0;
    m_tmo    = 0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic idle(input int n, input bit ordy);
    repeat (n) step(1'b0, '0, ordy);
  endtask

  logic [W-1:0] tok0;

  initial begin
    apply_reset();

    // single token, identity FFN answering 3 cycles after the issue pulse
    tok0    = {16'd1024, 16'd768, 16'd1280, 16'd1536};
    force_d = 3;
    ident   = 1;
    step(1'b1, tok0, 1'b1);
    idle(10, 1'b1);

    // FFN never answers, then answers on the last permitted cycle
    ident   = 0;
    force_d = 1000;
    step(1'b1, rnd_tok(), 1'b1);
    idle(TO + 6, 1'b1);
    force_d = TO;
    step(1'b1, rnd_tok(), 1'b1);
    idle(TO + 6, 1'b1);

    // fill the queue with the consumer stalled, try a fifth push, drain
    force_d = 2;
    ident   = 1;
    for (int i = 0; i < 5; i++) step(1'b1, rnd_tok(), 1'b0);
    idle(6, 1'b0);
    idle(40, 1'b1);

    // full queue in HOLD: push and release together
    for (int i = 0; i < 4; i++) step(1'b1, rnd_tok(), 1'b0);
    idle(8, 1'b0);
    step(1'b1, rnd_tok(), 1'b1);
    idle(2, 1'b0);
    idle(60, 1'b1);

    // random traffic with random FFN latency and spurious responses
    ident   = 0;
    force_d = -1;
    stray   = 1;
    repeat (1500)
      step(1'($urandom_range(0, 1)), rnd_tok(), ($urandom_range(0, 3) != 0));
    idle(200, 1'b1);
    stray = 0;

    // reset during WAIT with two tokens queued, then a stray response
    force_d = 1000;
    step(1'b1, rnd_tok(), 1'b0);
    step(1'b1, rnd_tok(), 1'b0);
    idle(4, 1'b0);
    apply_reset();
    stray = 2;
    idle(6, 1'b1);
    stray = 0;
    idle(1, 1'b1);
    #1;
    reset_check();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
